// File: rtl/streebog_round_const_stream.sv
// Streebog (GOST R 34.11-2012) round-constant sequencer.
// Holds C1..C12 in a registered ROM and streams a run of them as WORD_W-bit
// beats over a valid/ready interface, forward or reversed.
module streebog_round_const_stream #(
  parameter int unsigned WORD_W    = 64,
  parameter int unsigned NUM_CONST = 12,
  parameter bit          LSW_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              reverse,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic [3:0]        out_idx,
  output logic              out_last_word,
  output logic              out_last_const,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BEATS     = 512 / WORD_W;
  localparam logic [3:0]  LAST_BEAT = 4'(BEATS - 1);
  localparam logic [3:0]  TOP_IDX   = 4'(NUM_CONST - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DONE
  } state_t;

  state_t       state;
  logic [511:0] hold;
  logic [3:0]   idx;
  logic [3:0]   beat;
  logic         rev_q;
  logic [3:0]   final_idx;
  logic         xfer;
  logic [511:0] hold_next;

  // Round constants C1..C12, entry i = C(i+1), most significant word first.
  function automatic logic [511:0] rom_word(input logic [3:0] i);
    logic [511:0] w;
    case (i)
      4'd0:  w = {256'hb1085bda1ecadae9_ebcb2f81c0657c1f_2f6a76432e45d016_714eb88d7585c4fc,
                  256'h4b7ce09192676901_a2422a08a460d315_05767436cc744d23_dd806559f2a64507};
      4'd1:  w = {256'h6fa3b58aa99d2f1a_4fe39d460f70b5d7_f3feea720a232b98_61d55e0f16b50131,
                  256'h9ab5176b12d69958_5cb561c2db0aa7ca_55dda21bd7cbcd56_e679047021b19bb7};
      4'd2:  w = {256'hf574dcac2bce2fc7_0a39fc286a3d8435_06f15e5f529c1f8b_f2ea7514b1297b7b,
                  256'hd3e20fe490359eb1_c1c93a376062db09_c2b6f443867adb31_991e96f50aba0ab2};
      4'd3:  w = {256'hef1fdfb3e81566d2_f948e1a05d71e4dd_488e857e335c3c7d_9d721cad685e353f,
                  256'ha9d72c82ed03d675_d8b71333935203be_3453eaa193e837f1_220cbebc84e3d12e};
      4'd4:  w = {256'h4bea6bacad474799_9a3f410c6ca92363_7f151c1f1686104a_359e35d7800fffbd,
                  256'hbfcd1747253af5a3_dfff00b723271a16_7a56a27ea9ea63f5_601758fd7c6cfe57};
      4'd5:  w = {256'hae4faeae1d3ad3d9_6fa4c33b7a3039c0_2d66c4f95142a46c_187f9ab49af08ec6,
                  256'hcffaa6b71c9ab7b4_0af21f66c2bec6b6_bf71c57236904f35_fa68407a46647d6e};
      4'd6:  w = {256'hf4c70e16eeaac5ec_51ac86febf240954_399ec6c7e6bf87c9_d3473e33197a93c9,
                  256'h0992abc52d822c37_06476983284a0504_3517454ca23c4af3_8886564d3a14d493};
      4'd7:  w = {256'h9b1f5b424d93c9a7_03e7aa020c6e4141_4eb7f8719c36de1e_89b4443b4ddbc49a,
                  256'hf4892bcb929b0690_69d18d2bd1a5c42f_36acc2355951a8d9_a47f0dd4bf02e71e};
      4'd8:  w = {256'h378f5a541631229b_944c9ad8ec165fde_3a7d3a1b25894224_3cd955b7e00d0984,
                  256'h800a440bdbb2ceb1_7b2b8a9aa6079c54_0e38dc92cb1f2a60_7261445183235adb};
      4'd9:  w = {256'habbedea680056f52_382ae548b2e4f3f3_8941e71cff8a78db_1fffe18a1b336103,
                  256'h9fe76702af69334b_7a1e6c303b7652f4_3698fad1153bb6c3_74b4c7fb98459ced};
      4'd10: w = {256'h7bcd9ed0efc889fb_3002c6cd635afe94_d8fa6bbbebab0761_2001802114846679,
                  256'h8a1d71efea48b9ca_efbacd1d7d476e98_dea2594ac06fd85d_6bcaa4cd81f32d1b};
      4'd11: w = {256'h378ee767f11631ba_d21380b00449b17a_cda43c32bcdf1d77_f82012d430219f9b,
                  256'h5d80ef9d1891cc86_e71da4aa88e12852_faf417d5d9b21b99_48bc924af11bd720};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign xfer      = out_valid && out_ready;
  assign final_idx = rev_q ? 4'd0 : TOP_IDX;

  // Next holding-register value: move the following slice into the output window.
  always_comb begin
    hold_next = hold;
    if (LSW_FIRST) begin
      hold_next = hold >> WORD_W;
    end else begin
      hold_next = hold << WORD_W;
    end
  end

  // Output slice and flags, all decoded from registered state.
  always_comb begin
    out_data       = LSW_FIRST ? hold[WORD_W-1:0] : hold[511 -: WORD_W];
    out_idx        = idx;
    out_last_word  = out_valid && (beat == LAST_BEAT);
    out_last_const = out_valid && (idx == final_idx);
    busy           = (state != S_IDLE);
  end

  // Sequencer FSM: abort dominates every non-idle state and any same-cycle transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hold      <= '0;
      idx       <= '0;
      beat      <= '0;
      rev_q     <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      done      <= 1'b0;
      beat      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            rev_q <= reverse;
            idx   <= reverse ? TOP_IDX : 4'd0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          hold      <= rom_word(idx);
          beat      <= '0;
          out_valid <= 1'b1;
          state     <= S_STREAM;
        end
        S_STREAM: begin
          if (xfer) begin
            if (beat != LAST_BEAT) begin
              beat <= beat + 4'd1;
              hold <= hold_next;
            end else begin
              out_valid <= 1'b0;
              if (idx == final_idx) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                idx   <= rev_q ? (idx - 4'd1) : (idx + 4'd1);
                state <= S_LOAD;
              end
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_streebog_round_const_stream.sv
// Directed bench for streebog_round_const_stream: a 64-bit forward instance
// and a 512-bit instance used for reversed runs.
module tb_streebog_round_const_stream;

  logic         clk = 1'b0;
  logic         rst;

  logic         start, reverse, abort, out_ready;
  logic         out_valid, out_last_word, out_last_const, busy, done;
  logic [63:0]  out_data;
  logic [3:0]   out_idx;

  logic         b_start, b_reverse, b_abort, b_ready;
  logic         b_valid, b_last_word, b_last_const, b_busy, b_done;
  logic [511:0] b_data;
  logic [3:0]   b_idx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  streebog_round_const_stream #(.WORD_W(64), .NUM_CONST(12), .LSW_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .reverse(reverse), .abort(abort),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_last_word(out_last_word), .out_last_const(out_last_const),
    .busy(busy), .done(done)
  );

  streebog_round_const_stream #(.WORD_W(512), .NUM_CONST(12), .LSW_FIRST(1'b1)) dut512 (
    .clk(clk), .rst(rst), .start(b_start), .reverse(b_reverse), .abort(b_abort),
    .out_ready(b_ready), .out_valid(b_valid), .out_data(b_data),
    .out_idx(b_idx), .out_last_word(b_last_word), .out_last_const(b_last_const),
    .busy(b_busy), .done(b_done)
  );

  // Reference constants C1..C12 (GOST R 34.11-2012), MS word first.
  function automatic logic [511:0] ref_const(input int i);
    logic [511:0] c;
    case (i)
      0:  c = {256'hb1085bda1ecadae9_ebcb2f81c0657c1f_2f6a76432e45d016_714eb88d7585c4fc,
               256'h4b7ce09192676901_a2422a08a460d315_05767436cc744d23_dd806559f2a64507};
      1:  c = {256'h6fa3b58aa99d2f1a_4fe39d460f70b5d7_f3feea720a232b98_61d55e0f16b50131,
               256'h9ab5176b12d69958_5cb561c2db0aa7ca_55dda21bd7cbcd56_e679047021b19bb7};
      2:  c = {256'hf574dcac2bce2fc7_0a39fc286a3d8435_06f15e5f529c1f8b_f2ea7514b1297b7b,
               256'hd3e20fe490359eb1_c1c93a376062db09_c2b6f443867adb31_991e96f50aba0ab2};
      3:  c = {256'hef1fdfb3e81566d2_f948e1a05d71e4dd_488e857e335c3c7d_9d721cad685e353f,
               256'ha9d72c82ed03d675_d8b71333935203be_3453eaa193e837f1_220cbebc84e3d12e};
      4:  c = {256'h4bea6bacad474799_9a3f410c6ca92363_7f151c1f1686104a_359e35d7800fffbd,
               256'hbfcd1747253af5a3_dfff00b723271a16_7a56a27ea9ea63f5_601758fd7c6cfe57};
      5:  c = {256'hae4faeae1d3ad3d9_6fa4c33b7a3039c0_2d66c4f95142a46c_187f9ab49af08ec6,
               256'hcffaa6b71c9ab7b4_0af21f66c2bec6b6_bf71c57236904f35_fa68407a46647d6e};
      6:  c = {256'hf4c70e16eeaac5ec_51ac86febf240954_399ec6c7e6bf87c9_d3473e33197a93c9,
               256'h0992abc52d822c37_06476983284a0504_3517454ca23c4af3_8886564d3a14d493};
      7:  c = {256'h9b1f5b424d93c9a7_03e7aa020c6e4141_4eb7f8719c36de1e_89b4443b4ddbc49a,
               256'hf4892bcb929b0690_69d18d2bd1a5c42f_36acc2355951a8d9_a47f0dd4bf02e71e};
      8:  c = {256'h378f5a541631229b_944c9ad8ec165fde_3a7d3a1b25894224_3cd955b7e00d0984,
               256'h800a440bdbb2ceb1_7b2b8a9aa6079c54_0e38dc92cb1f2a60_7261445183235adb};
      9:  c = {256'habbedea680056f52_382ae548b2e4f3f3_8941e71cff8a78db_1fffe18a1b336103,
               256'h9fe76702af69334b_7a1e6c303b7652f4_3698fad1153bb6c3_74b4c7fb98459ced};
      10: c = {256'h7bcd9ed0efc889fb_3002c6cd635afe94_d8fa6bbbebab0761_2001802114846679,
               256'h8a1d71efea48b9ca_efbacd1d7d476e98_dea2594ac06fd85d_6bcaa4cd81f32d1b};
      11: c = {256'h378ee767f11631ba_d21380b00449b17a_cda43c32bcdf1d77_f82012d430219f9b,
               256'h5d80ef9d1891cc86_e71da4aa88e12852_faf417d5d9b21b99_48bc924af11bd720};
      default: c = '0;
    endcase
    return c;
  endfunction

  // 64-bit beat k of constant i, least significant word first.
  function automatic logic [63:0] exp_beat(input int i, input int k);
    logic [511:0] c;
    c = ref_const(i) >> (64 * k);
    return c[63:0];
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on the 64-bit instance; returns #1 after the edge that sampled it.
  task automatic start_run(input logic rev);
    @(posedge clk); #1;
    start   = 1'b1;
    reverse = rev;
    @(posedge clk); #1;
    start   = 1'b0;
    reverse = 1'b0;
  endtask

  // Walk one forward run on the 64-bit instance, checking every accepted beat.
  // mode 0: out_ready held high; mode 1: random 50% out_ready.
  task automatic stream_check(input int mode, input bit poke_start);
    int          cyc, beats, done_cyc, first_cyc;
    bit          got_done, stalled, rdy;
    logic [63:0] prev_data;
    logic [3:0]  prev_idx;
    int          ei, ek;
    cyc = 1; beats = 0; done_cyc = 0; first_cyc = 0;
    got_done = 1'b0; stalled = 1'b0;
    prev_data = '0; prev_idx = '0;
    while (!got_done && cyc < 1500) begin
      if (stalled) begin
        chk("stall_valid", 512'(out_valid), 512'd1);
        chk("stall_data",  512'(out_data),  512'(prev_data));
        chk("stall_idx",   512'(out_idx),   512'(prev_idx));
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end else begin
        rdy       = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        out_ready = rdy;
        start     = (poke_start && (cyc == 20 || cyc == 57));
        if (out_valid && first_cyc == 0) first_cyc = cyc;
        if (out_valid && rdy) begin
          ei = beats / 8;
          ek = beats % 8;
          chk("beat_data", 512'(out_data), 512'(exp_beat(ei, ek)));
          chk("beat_idx",  512'(out_idx),  512'(ei));
          chk("last_word", 512'(out_last_word),  512'(ek == 7));
          chk("last_const", 512'(out_last_const), 512'(ei == 11));
          if (beats == 0)  chk("beat0_lit",  512'(out_data), 512'h dd806559f2a64507);
          if (beats == 7)  chk("beat7_lit",  512'(out_data), 512'h b1085bda1ecadae9);
          if (beats == 95) chk("beat95_lit", 512'(out_data), 512'h 378ee767f11631ba);
          beats++;
          stalled = 1'b0;
        end else if (out_valid) begin
          stalled   = 1'b1;
          prev_data = out_data;
          prev_idx  = out_idx;
        end else begin
          stalled = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_seen",  512'(got_done), 512'd1);
    chk("beat_count", 512'(beats),    512'd96);
    if (mode == 0) begin
      // start sampled in cycle t; done in cycle t+109, i.e. 110 cycles inclusive
      chk("done_cycle",  512'(done_cyc),  512'd109);
      chk("first_valid", 512'(first_cyc), 512'd2);
    end
    @(posedge clk); #1;
    chk("done_pulse_end", 512'(done), 512'd0);
    chk("idle_busy",      512'(busy), 512'd0);
    out_ready = 1'b0;
  endtask

  // Advance the 64-bit instance (ready high) until beat number n is presented.
  task automatic run_to_beat(input int n, output bit found);
    int cnt;
    cnt = 0;
    found = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 300 && !found; c++) begin
      if (out_valid && cnt == n) begin
        found = 1'b1;
      end else begin
        if (out_valid) cnt++;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    bit found, seen_done, b_got_done;
    int j;

    rst = 1'b1;
    start = 1'b0; reverse = 1'b0; abort = 1'b0; out_ready = 1'b0;
    b_start = 1'b0; b_reverse = 1'b0; b_abort = 1'b0; b_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",      512'(out_valid),      512'd0);
    chk("rst_busy",       512'(busy),           512'd0);
    chk("rst_done",       512'(done),           512'd0);
    chk("rst_data",       512'(out_data),       512'd0);
    chk("rst_idx",        512'(out_idx),        512'd0);
    chk("rst_last_word",  512'(out_last_word),  512'd0);
    chk("rst_last_const", 512'(out_last_const), 512'd0);
    rst = 1'b0;

    // Forward run, ready high.
    start_run(1'b0);
    chk("load_busy",  512'(busy),      512'd1);
    chk("load_valid", 512'(out_valid), 512'd0);
    stream_check(0, 1'b0);

    // Forward run with start pulses injected mid-stream.
    start_run(1'b0);
    stream_check(0, 1'b1);

    // Forward run with random back-pressure.
    start_run(1'b0);
    stream_check(1, 1'b0);

    // Reversed run on the 512-bit instance.
    @(posedge clk); #1;
    b_start = 1'b1; b_reverse = 1'b1; b_ready = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0; b_reverse = 1'b0;
    j = 0;
    b_got_done = 1'b0;
    for (int c = 0; c < 100 && !b_got_done; c++) begin
      if (b_done) begin
        b_got_done = 1'b1;
      end else begin
        if (b_valid) begin
          chk("rev_data",       b_data,                ref_const(11 - j));
          chk("rev_idx",        512'(b_idx),           512'(11 - j));
          chk("rev_last_word",  512'(b_last_word),     512'd1);
          chk("rev_last_const", 512'(b_last_const),    512'(j == 11));
          if (j == 0) chk("rev_first_lsw", 512'(b_data[63:0]), 512'h 48bc924af11bd720);
          j++;
        end
        @(posedge clk); #1;
      end
    end
    chk("rev_done_seen", 512'(b_got_done), 512'd1);
    chk("rev_beats",     512'(j),          512'd12);
    b_ready = 1'b0;

    // Abort while idx 5 beat 3 is presented and accepted in the same cycle.
    start_run(1'b0);
    run_to_beat(43, found);
    chk("abort_reach", 512'(found),    512'd1);
    chk("abort_idx",   512'(out_idx),  512'd5);
    chk("abort_data",  512'(out_data), 512'(exp_beat(5, 3)));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid", 512'(out_valid), 512'd0);
    chk("abort_busy",  512'(busy),      512'd0);
    chk("abort_done",  512'(done),      512'd0);
    seen_done = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen_done = seen_done | done | busy;
    end
    chk("abort_quiet", 512'(seen_done), 512'd0);
    start_run(1'b0);
    @(posedge clk); #1;
    chk("replay_valid", 512'(out_valid), 512'd1);
    chk("replay_idx",   512'(out_idx),   512'd0);
    chk("replay_data",  512'(out_data),  512'h dd806559f2a64507);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    out_ready = 1'b0;

    // start and abort together in IDLE.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("sa_busy",  512'(busy),      512'd0);
    chk("sa_valid", 512'(out_valid), 512'd0);
    @(posedge clk); #1;
    chk("sa_busy2", 512'(busy),      512'd0);

    // Asynchronous reset mid-run at idx 3 beat 2.
    start_run(1'b0);
    run_to_beat(26, found);
    chk("rstm_reach", 512'(found),    512'd1);
    chk("rstm_data",  512'(out_data), 512'(exp_beat(3, 2)));
    #2;
    rst = 1'b1;
    #1;
    chk("rstm_valid", 512'(out_valid),      512'd0);
    chk("rstm_busy",  512'(busy),           512'd0);
    chk("rstm_done",  512'(done),           512'd0);
    chk("rstm_idx",   512'(out_idx),        512'd0);
    chk("rstm_out",   512'(out_data),       512'd0);
    chk("rstm_lc",    512'(out_last_const), 512'd0);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    start_run(1'b0);
    @(posedge clk); #1;
    chk("post_rst_valid", 512'(out_valid), 512'd1);
    chk("post_rst_idx",   512'(out_idx),   512'd0);
    chk("post_rst_data",  512'(out_data),  512'h dd806559f2a64507);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
